// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS datapath: word load/store with a fixed number of
// wait states, a stall back to the core, misaligned-access error, and a debug read port.
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        stall,
    output logic        err,
    input  logic [4:0]  disp_sel,
    output logic [31:0] disp_dat
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic                    mis_q, mis_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wd_q, wd_d;
    logic [31:0]             rd_q, rd_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [31:0]             mem_q [DEPTH];
    logic                    enter_resp_s;
    logic [DEPTH_LOG2-1:0]   disp_idx_s;
    logic                    unused_addr_s;

    // Next-state logic; the access is latched in IDLE so a zero-wait response can use it directly.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        mis_d        = mis_q;
        idx_d        = idx_q;
        wd_d         = wd_q;
        rd_d         = rd_q;
        ready_d      = 1'b0;
        err_d        = 1'b0;
        enter_resp_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d  = mem_write;
                    mis_d = (addr[1:0] != 2'd0);
                    idx_d = addr[DEPTH_LOG2+1:2];
                    wd_d  = wd;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = S_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Response flags and load data are registered on the edge into RESP.
        if (enter_resp_s) begin
            ready_d = 1'b1;
            err_d   = mis_d;
            if (!wr_d && !mis_d) begin
                rd_d = mem_q[idx_d];
            end else begin
                rd_d = rd_q;
            end
        end else begin
            ready_d = 1'b0;
        end
    end

    // Control and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage array: cleared by reset, written at the end of an aligned store's RESP cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (state_q == S_RESP && wr_q && !mis_q) begin
            mem_q[idx_q] <= wd_q;
        end
    end

    assign disp_idx_s    = DEPTH_LOG2'(disp_sel);
    assign disp_dat      = mem_q[disp_idx_s];
    assign unused_addr_s = ^addr[31:DEPTH_LOG2+2];

    assign stall = ((state_q != S_IDLE) && (state_q != S_RESP)) || ((state_q == S_IDLE) && req);
    assign rd    = rd_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses two wait states, instance 1 none;
// expected responses come from a per-instance memory model and a response queue.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_v       [2];
    logic        mem_write_v [2];
    logic [31:0] addr_v      [2];
    logic [31:0] wd_v        [2];
    logic [31:0] rd_v        [2];
    logic        ready_v     [2];
    logic        stall_v     [2];
    logic        err_v       [2];
    logic [31:0] disp_v      [2];
    logic [4:0]  disp_sel;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [2][64];
    logic [31:0] model_rd  [2];

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    data_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) dut_w2 (
        .clock(clock), .reset(reset), .req(req_v[0]), .mem_write(mem_write_v[0]),
        .addr(addr_v[0]), .wd(wd_v[0]), .rd(rd_v[0]), .ready(ready_v[0]),
        .stall(stall_v[0]), .err(err_v[0]), .disp_sel(disp_sel), .disp_dat(disp_v[0])
    );

    data_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut_w0 (
        .clock(clock), .reset(reset), .req(req_v[1]), .mem_write(mem_write_v[1]),
        .addr(addr_v[1]), .wd(wd_v[1]), .rd(rd_v[1]), .ready(ready_v[1]),
        .stall(stall_v[1]), .err(err_v[1]), .disp_sel(disp_sel), .disp_dat(disp_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_models();
        for (int b = 0; b < 2; b++) begin
            model_rd[b] = 32'd0;
            for (int i = 0; i < 64; i++) model_mem[b][i] = 32'd0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int b = 0; b < 2; b++) begin
            req_v[b] = 1'b0; mem_write_v[b] = 1'b0; addr_v[b] = 32'd0; wd_v[b] = 32'd0;
        end
        @(negedge clock);
        reset = 1'b0;
        clear_models();
    endtask

    task automatic disp_chk(input int b, input int sel, input string tag);
        @(negedge clock);
        disp_sel = 5'(sel);
        #1;
        chk(tag, disp_v[b], model_mem[b][sel]);
    endtask

    // One load/store on instance b; expectation queued at drive time, checked at ready.
    task automatic access(input int b, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int wait_cyc, input string tag);
        exp_t e;
        exp_t got;
        int   idx;
        bit   mis;
        int   lat;
        int   stall_hi;
        bit   seen;
        idx   = int'(a[7:2]);
        mis   = (a[1:0] != 2'd0);
        e.err = mis;
        e.lat = wait_cyc + 1;
        e.rd  = (!w && !mis) ? model_mem[b][idx] : model_rd[b];
        @(negedge clock);
        req_v[b] = 1'b1; mem_write_v[b] = w; addr_v[b] = a; wd_v[b] = d;
        sb.push_back(e);
        #1;
        stall_hi = stall_v[b] ? 1 : 0;
        @(posedge clock);
        #1;
        req_v[b] = 1'b0; mem_write_v[b] = ~w; addr_v[b] = 32'hFFFF_FFFF; wd_v[b] = ~d;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clock);
            lat++;
            if (ready_v[b]) seen = 1'b1;
            else if (stall_v[b]) stall_hi++;
        end
        got = sb.pop_front();
        chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
            chk({tag, "_stall_cycles"}, 32'(stall_hi), 32'(got.lat));
            chk({tag, "_stall_at_ready"}, 32'(stall_v[b]), 32'd0);
            chk({tag, "_rd"}, rd_v[b], got.rd);
            chk({tag, "_err"}, 32'(err_v[b]), 32'(got.err));
        end
        if (w && !mis) model_mem[b][idx] = d;
        model_rd[b] = got.rd;
        @(negedge clock);
        chk({tag, "_ready_drop"}, 32'(ready_v[b]), 32'd0);
        chk({tag, "_err_drop"}, 32'(err_v[b]), 32'd0);
        chk({tag, "_rd_hold"}, rd_v[b], got.rd);
    endtask

    initial begin
        int ready_cnt;
        reset    = 1'b1;
        disp_sel = 5'd0;
        for (int b = 0; b < 2; b++) begin
            req_v[b] = 1'b0; mem_write_v[b] = 1'b0; addr_v[b] = 32'd0; wd_v[b] = 32'd0;
        end
        clear_models();
        repeat (2) @(negedge clock);
        do_reset();

        // Reset state and a clear memory.
        #1;
        chk("rst_rd", rd_v[0], 32'd0);
        chk("rst_ready", 32'(ready_v[0]), 32'd0);
        chk("rst_err", 32'(err_v[0]), 32'd0);
        chk("rst_stall", 32'(stall_v[0]), 32'd0);
        for (int s = 0; s < 32; s++) disp_chk(0, s, "rst_disp");
        disp_chk(1, 31, "rst_disp_w0");

        // Store, load back, misaligned store and load.
        access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, "st10");
        disp_chk(0, 4, "st10_disp");
        access(0, 1'b0, 32'h0000_0010, 32'h0000_0000, 2, "ld10");
        access(0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 2, "st13_mis");
        disp_chk(0, 4, "st13_disp");
        access(0, 1'b0, 32'h0000_0012, 32'h0000_0000, 2, "ld12_mis");
        access(0, 1'b0, 32'h0000_0008, 32'h0000_0000, 2, "ld08_empty");

        // Address aliasing on both wait settings.
        access(0, 1'b1, 32'h0000_0104, 32'h1234_5678, 2, "st104");
        access(0, 1'b0, 32'h0000_0004, 32'h0000_0000, 2, "ld04");
        access(1, 1'b1, 32'h0000_0104, 32'h1234_5678, 0, "w0_st104");
        access(1, 1'b0, 32'h0000_0004, 32'h0000_0000, 0, "w0_ld04");
        disp_chk(1, 1, "w0_disp1");
        access(1, 1'b1, 32'h8000_00FC, 32'hA5A5_0F0F, 0, "w0_st_top");
        disp_chk(1, 31, "w0_disp31");
        access(1, 1'b1, 32'h0000_0001, 32'h5555_AAAA, 0, "w0_st_mis");
        access(1, 1'b0, 32'h0000_00FC, 32'h0000_0000, 0, "w0_ld_top");

        // Reset in the middle of a store: nothing completes and memory is cleared.
        access(0, 1'b1, 32'h0000_0008, 32'hAAAA_5555, 2, "st08");
        disp_chk(0, 2, "st08_disp");
        @(negedge clock);
        req_v[0] = 1'b1; mem_write_v[0] = 1'b1; addr_v[0] = 32'h0000_0008; wd_v[0] = 32'h1111_2222;
        @(posedge clock);
        #1;
        req_v[0] = 1'b0;
        @(negedge clock);
        chk("rstmid_stall_wait", 32'(stall_v[0]), 32'd1);
        reset = 1'b1;
        ready_cnt = 0;
        @(negedge clock);
        reset = 1'b0;
        clear_models();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (ready_v[0]) ready_cnt++;
        end
        chk("rstmid_ready_cnt", 32'(ready_cnt), 32'd0);
        chk("rstmid_stall", 32'(stall_v[0]), 32'd0);
        chk("rstmid_rd", rd_v[0], 32'd0);
        disp_chk(0, 2, "rstmid_disp2");
        disp_chk(0, 4, "rstmid_disp4");
        access(0, 1'b0, 32'h0000_0008, 32'h0000_0000, 2, "rstmid_ld08");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
